// File: rtl/audio_lj_receiver.sv
// Left-justified codec ADC receiver: captures L/R words from an external bit clock into a valid/ready sample pair.
// Optional build macro AUD_RX_MONO_MIX_EN adds a registered sample_mono output (average of left and right).
`timescale 1ns/1ps
module audio_lj_receiver #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aud_bclk,
  input  logic              aud_adclrc,
  input  logic              aud_adcdat,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err,
  input  logic              flag_clr
`ifdef AUD_RX_MONO_MIX_EN
  ,
  output logic [DATA_W-1:0] sample_mono
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  typedef enum logic [1:0] {SEEK, LEFT, RIGHT} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync, lrc_sync, dat_sync;
  logic bclk_s, lrc_s, dat_s, bclk_d, strobe;
  logic lrc_prev, primed, rise, fall;

  state_t state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg, left_word;
  logic start_ch, shift_en, latch_left, pair_form, set_ferr, load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], aud_bclk};
      lrc_sync  <= {lrc_sync[SYNC_STAGES-2:0], aud_adclrc};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], aud_adcdat};
      bclk_d    <= bclk_s;
    end
  end

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign lrc_s  = lrc_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];
  assign strobe = bclk_s & ~bclk_d;

  // The first strobe after reset only records lrc, so a reset released
  // mid-left-channel cannot look like a fresh left start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lrc_prev <= 1'b0;
      primed   <= 1'b0;
    end else if (strobe) begin
      lrc_prev <= lrc_s;
      primed   <= 1'b1;
    end
  end

  assign rise = primed &  lrc_s & ~lrc_prev;
  assign fall = primed & ~lrc_s &  lrc_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEEK;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_ch   = 1'b0;
    shift_en   = 1'b0;
    latch_left = 1'b0;
    pair_form  = 1'b0;
    set_ferr   = 1'b0;
    if (strobe) begin
      case (state)
        SEEK: begin
          if (rise) begin
            state_nx = LEFT;
            start_ch = 1'b1;
          end
        end
        LEFT, RIGHT: begin
          if (rise || fall) begin
            if (state == LEFT && fall && cnt == CNT_FULL) begin
              latch_left = 1'b1;
              start_ch   = 1'b1;
              state_nx   = RIGHT;
            end else if (state == RIGHT && rise && cnt == CNT_FULL) begin
              pair_form = 1'b1;
              start_ch  = 1'b1;
              state_nx  = LEFT;
            end else begin
              // Short channel: drop the pair; a rising edge immediately re-enters LEFT.
              set_ferr = 1'b1;
              if (rise) begin
                start_ch = 1'b1;
                state_nx = LEFT;
              end else begin
                state_nx = SEEK;
              end
            end
          end else if (cnt != CNT_FULL) begin
            shift_en = 1'b1;
          end
        end
        default: state_nx = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      shreg     <= '0;
      left_word <= '0;
    end else if (start_ch) begin
      if (latch_left) left_word <= shreg;
      shreg <= {{(DATA_W-1){1'b0}}, dat_s};
      cnt   <= CNT_W'(1);
    end else if (shift_en) begin
      shreg <= {shreg[DATA_W-2:0], dat_s};
      cnt   <= cnt + CNT_W'(1);
    end else if (set_ferr) begin
      cnt <= '0;
    end
  end

  assign load = pair_form & (~sample_valid | sample_ready);

`ifdef AUD_RX_MONO_MIX_EN
  logic [DATA_W:0] mono_sum;
  assign mono_sum = {left_word[DATA_W-1], left_word} + {shreg[DATA_W-1], shreg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     sample_mono <= '0;
    else if (load) sample_mono <= mono_sum[DATA_W:1];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
    end else if (load) begin
      sample_left  <= left_word;
      sample_right <= shreg;
      sample_valid <= 1'b1;
    end else if (sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (pair_form && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (flag_clr)                              overrun <= 1'b0;
      if (set_ferr)      frame_err <= 1'b1;
      else if (flag_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_lj_receiver.sv
// Bench for audio_lj_receiver: drives a left-justified codec stream and checks pairs and flags against a channel-level model.
`timescale 1ns/1ps
module tb_audio_lj_receiver;
  localparam int W = 16;

  logic clk = 1'b0, reset = 1'b1;
  logic aud_bclk = 1'b0, aud_adclrc = 1'b0, aud_adcdat = 1'b0;
  logic sample_ready = 1'b1, flag_clr = 1'b0;
  logic [W-1:0] sample_left, sample_right;
  logic sample_valid, overrun, frame_err;
`ifdef AUD_RX_MONO_MIX_EN
  logic [W-1:0] sample_mono;
`endif

  always #5 clk = ~clk;
  always #41 aud_bclk = ~aud_bclk;

  audio_lj_receiver #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .aud_bclk(aud_bclk), .aud_adclrc(aud_adclrc), .aud_adcdat(aud_adcdat),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .frame_err(frame_err), .flag_clr(flag_clr)
`ifdef AUD_RX_MONO_MIX_EN
    , .sample_mono(sample_mono)
`endif
  );

  int n_tests = 0, n_fail = 0, valid_hi = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel-level reference: a channel is (lrc, number of bit clocks, word).
  logic [31:0] exp_q[$];
  bit m_locked, m_have_low, m_prev_valid, m_left_full, m_prev_lrc;
  int m_prev_slot;
  logic [15:0] m_prev_word, m_left_word;
  bit exp_ovr, exp_ferr;

  function automatic void model_reset();
    exp_q.delete();
    m_locked = 0; m_have_low = 0; m_prev_valid = 0; m_left_full = 0;
    exp_ovr = 0; exp_ferr = 0;
  endfunction

  function automatic void push_pair(logic [15:0] l, logic [15:0] r);
    if (!sample_ready && exp_q.size() > 0) exp_ovr = 1;
    else exp_q.push_back({l, r});
  endfunction

  function automatic void model_chan(bit lrc, int slot, logic [15:0] word);
    if (m_locked && m_prev_valid && lrc != m_prev_lrc) begin
      if (m_prev_slot < W) begin
        exp_ferr = 1;
        m_locked = 0;
      end else if (m_prev_lrc) begin
        m_left_full = 1;
        m_left_word = m_prev_word;
      end else if (m_left_full) begin
        push_pair(m_left_word, m_prev_word);
      end
    end
    if (lrc && m_have_low) m_locked = 1;
    if (lrc) m_left_full = 0;
    else     m_have_low = 1;
    m_prev_lrc = lrc; m_prev_slot = slot; m_prev_word = word; m_prev_valid = 1;
  endfunction

`ifdef AUD_RX_MONO_MIX_EN
  function automatic logic [15:0] mono_ref(logic [31:0] p);
    int s;
    s = int'($signed(p[31:16])) + int'($signed(p[15:0]));
    s = s >>> 1;
    return s[15:0];
  endfunction
`endif

  always @(negedge clk) begin
    logic [31:0] p;
    if (sample_valid) begin
      valid_hi++;
      if (sample_ready) begin
        check("pair_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          p = exp_q.pop_front();
          check("pair", {sample_left, sample_right}, p);
`ifdef AUD_RX_MONO_MIX_EN
          check("mono", sample_mono, mono_ref(p));
`endif
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check(tag, {sample_left, sample_right, sample_valid, overrun, frame_err}, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic send_chan(input bit lrc, input logic [15:0] word, input int slot, input int rst_bit = -1);
    model_chan(lrc, slot, word);
    for (int i = 0; i < slot; i++) begin
      @(negedge aud_bclk);
      aud_adclrc = lrc;
      aud_adcdat = (i < W) ? word[15-i] : 1'($urandom);
      if (i == rst_bit) do_reset();
    end
  endtask

  task automatic set_ready(input bit v);
    @(posedge clk); #2 sample_ready = v;
  endtask

  task automatic pulse_flag_clr();
    @(posedge clk); #2 flag_clr = 1'b1;
    @(posedge clk); #2 flag_clr = 1'b0;
    exp_ovr = 0; exp_ferr = 0;
  endtask

  task automatic check_flags(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_overrun"}, overrun, exp_ovr);
    check({tag, "_frame_err"}, frame_err, exp_ferr);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  function automatic logic [15:0] rnd();
    return 16'($urandom);
  endfunction

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lrc;
    int slot;
    model_reset();
    repeat (4) @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #2 reset = 1'b0;

    // Basic frame with ready held high: one-cycle valid pulse.
    valid_hi = 0;
    send_chan(0, rnd(), 8);
    send_chan(1, 16'hA5C3, 20);
    send_chan(0, 16'h1234, 20);
    send_chan(1, rnd(), 20);
    check("s1_valid_cycles", valid_hi, 1);
    check_flags("s1");

    // Overrun: ready low across two pairs.
    do_reset();
    send_chan(0, rnd(), 8);
    set_ready(0);
    send_chan(1, 16'h1111, 20);
    send_chan(0, 16'h2222, 20);
    send_chan(1, 16'h3333, 20);
    send_chan(0, 16'h4444, 20);
    send_chan(1, rnd(), 20);
    @(negedge clk);
    check("s2_held", {sample_valid, sample_left, sample_right}, {1'b1, 16'h1111, 16'h2222});
    check("s2_overrun_set", overrun, 1);
    check("s2_overrun_model", overrun, exp_ovr);
    pulse_flag_clr();
    @(negedge clk);
    check("s2_overrun_clr", overrun, 0);
    set_ready(1);
    check_flags("s2");

    // Left channel cut to 10 bits, then a clean frame.
    send_chan(0, rnd(), 20);
    send_chan(1, rnd(), 10);
    send_chan(0, rnd(), 20);
    @(negedge clk);
    check("s3_frame_err_set", frame_err, 1);
    send_chan(1, 16'h0F0F, 20);
    send_chan(0, 16'hF0F0, 20);
    send_chan(1, rnd(), 20);
    check_flags("s3");
    pulse_flag_clr();
    check_flags("s3_clr");

    // Start in the middle of a right channel.
    do_reset();
    send_chan(0, rnd(), 7);
    send_chan(1, rnd(), 20);
    send_chan(0, rnd(), 20);
    send_chan(1, rnd(), 20);
    check_flags("s4");

    // Reset during bit 8 of a left channel.
    send_chan(0, rnd(), 20);
    send_chan(1, rnd(), 20, 8);
    send_chan(0, rnd(), 20);
    send_chan(1, 16'h7FFF, 20);
    send_chan(0, 16'h8000, 20);
    send_chan(1, rnd(), 20);
    check_flags("s5");

    // Mono extremes, then randomized frames with occasional short channels.
    send_chan(0, rnd(), 20);
    send_chan(1, 16'h7FFF, 20);
    send_chan(0, 16'h7FFF, 20);
    send_chan(1, 16'h8000, 20);
    send_chan(0, 16'h0000, 20);
    lrc = 1;
    for (int i = 0; i < 40; i++) begin
      slot = ($urandom_range(7) == 0) ? int'($urandom_range(15, 8)) : int'($urandom_range(24, 16));
      send_chan(lrc, rnd(), slot);
      lrc = ~lrc;
    end
    send_chan(1, rnd(), 20);
    check_flags("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
